// File: rtl/ram_pkg.sv
// Shared defaults and entry type for the RAM shift buffer family.
package ram_pkg;
    localparam int RAM_WIDTH_DEF = 4;
    localparam int RAM_DEPTH_DEF = 8;

    typedef logic [RAM_WIDTH_DEF-1:0] ram_word_t;
endpackage

// File: rtl/ram_sat_counter.sv
// Saturating occupancy counter with synchronous reset and clear; clear+inc restarts at one.
module ram_sat_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] count_r;

    // Occupancy register: reset > clear > increment, holding at MAX.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= inc ? CW'(1) : '0;
        end else if (inc && (count_r != MAX_C)) begin
            count_r <= count_r + CW'(1);
        end
    end

    assign count = count_r;
    assign full  = (count_r == MAX_C);
    assign empty = (count_r == '0);
endmodule

// File: rtl/ram_shift_buffer.sv
// Parametrised shift buffer with random read tap, legacy oldest taps and occupancy.
// Optional RAM_SHIFT_EVICT_EN adds registered evict_valid/evict_data for entries lost on a full write.
module ram_shift_buffer
    import ram_pkg::*;
#(
    parameter int  WIDTH = RAM_WIDTH_DEF,
    parameter int  DEPTH = RAM_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             write,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
`ifdef RAM_SHIFT_EVICT_EN
    output logic             evict_valid,
    output logic [WIDTH-1:0] evict_data,
`endif
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] entry_r [DEPTH];

    // Entry array: clear zeroes every slot so unwritten reads return 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entry_r[i] <= '0;
        end else if (clear) begin
            entry_r[0] <= write ? data_in : '0;
            for (int i = 1; i < DEPTH; i++) entry_r[i] <= '0;
        end else if (write) begin
            entry_r[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) entry_r[i] <= entry_r[i-1];
        end
    end

    // Random read tap; addresses past the array (non-power-of-2 DEPTH) read as 0.
    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < DEPTH) begin
            rd_data = entry_r[rd_addr];
        end else begin
            rd_data = '0;
        end
    end

    assign data_out1 = entry_r[DEPTH-1];
    assign data_out2 = entry_r[DEPTH-2];

    ram_sat_counter #(
        .MAX (DEPTH),
        .CW  (AW + 1)
    ) u_count (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (write),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef RAM_SHIFT_EVICT_EN
    logic             evict_valid_r;
    logic [WIDTH-1:0] evict_data_r;

    // Capture the oldest entry as it is pushed out by a write while full.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            evict_valid_r <= 1'b0;
            evict_data_r  <= '0;
        end else if (write && full) begin
            evict_valid_r <= 1'b1;
            evict_data_r  <= entry_r[DEPTH-1];
        end else begin
            evict_valid_r <= 1'b0;
        end
    end

    assign evict_valid = evict_valid_r;
    assign evict_data  = evict_data_r;
`endif
endmodule

// File: tb/tb_ram_shift_buffer.sv
// Directed self-checking bench for ram_shift_buffer (DEPTH=8 and DEPTH=5 instances).
module tb_ram_shift_buffer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       write = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic [2:0] rd_addr = 3'd0;
    logic [3:0] rd_data, data_out1, data_out2;
    logic [3:0] count;
    logic       full, empty;
`ifdef RAM_SHIFT_EVICT_EN
    logic       evict_valid;
    logic [3:0] evict_data;
    logic       evict_valid5;
    logic [3:0] evict_data5;
`endif

    logic       write5 = 1'b0;
    logic [3:0] data_in5 = 4'h0;
    logic [2:0] rd_addr5 = 3'd0;
    logic [3:0] rd_data5, data_out15, data_out25;
    logic [3:0] count5;
    logic       full5, empty5;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ram_shift_buffer #(.WIDTH(4), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .clear(clear), .write(write),
        .data_in(data_in), .rd_addr(rd_addr), .rd_data(rd_data),
        .data_out1(data_out1), .data_out2(data_out2),
`ifdef RAM_SHIFT_EVICT_EN
        .evict_valid(evict_valid), .evict_data(evict_data),
`endif
        .count(count), .full(full), .empty(empty)
    );

    ram_shift_buffer #(.WIDTH(4), .DEPTH(5)) dut5 (
        .clock(clock), .reset(reset), .clear(1'b0), .write(write5),
        .data_in(data_in5), .rd_addr(rd_addr5), .rd_data(rd_data5),
        .data_out1(data_out15), .data_out2(data_out25),
`ifdef RAM_SHIFT_EVICT_EN
        .evict_valid(evict_valid5), .evict_data(evict_data5),
`endif
        .count(count5), .full(full5), .empty(empty5)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; write = 1'b0; write5 = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [3:0] v);
        write = 1'b1; data_in = v;
        tick();
        write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rd_addr = 3'd0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
        total++; if (data_out1 !== 4'h0 || data_out2 !== 4'h0 || rd_data !== 4'h0) begin bad++; $display("FAIL reset_taps got %h %h %h exp 0 0 0", data_out1, data_out2, rd_data); end
`ifdef RAM_SHIFT_EVICT_EN
        total++; if (evict_valid !== 1'b0) begin bad++; $display("FAIL reset_evict got=%b exp=0", evict_valid); end
`endif
    endtask

    task automatic test_fill();
        do_reset();
        rd_addr = 3'd0;
        push(4'd1);
        total++; if (rd_data !== 4'd1 || count !== 4'd1) begin bad++; $display("FAIL first_write got rd=%h cnt=%0d exp 1/1", rd_data, count); end
        for (int v = 2; v <= 8; v++) push(4'(v));
        total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL fill_count got cnt=%0d full=%b exp 8/1", count, full); end
        total++; if (data_out1 !== 4'd1 || data_out2 !== 4'd2) begin bad++; $display("FAIL fill_oldest got %h %h exp 1 2", data_out1, data_out2); end
        total++; if (rd_data !== 4'd8) begin bad++; $display("FAIL fill_rd0 got=%h exp=8", rd_data); end
        rd_addr = 3'd3; #1;
        total++; if (rd_data !== 4'd5) begin bad++; $display("FAIL fill_rd3 got=%h exp=5", rd_data); end
    endtask

    task automatic test_overflow();
        rd_addr = 3'd0;
        push(4'd9);
        total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL ovf_count got cnt=%0d full=%b exp 8/1", count, full); end
        total++; if (data_out1 !== 4'd2 || data_out2 !== 4'd3 || rd_data !== 4'd9) begin bad++; $display("FAIL ovf_taps got %h %h %h exp 2 3 9", data_out1, data_out2, rd_data); end
`ifdef RAM_SHIFT_EVICT_EN
        total++; if (evict_valid !== 1'b1 || evict_data !== 4'd1) begin bad++; $display("FAIL ovf_evict got v=%b d=%h exp 1/1", evict_valid, evict_data); end
        tick();
        total++; if (evict_valid !== 1'b0) begin bad++; $display("FAIL ovf_evict_pulse got=%b exp=0", evict_valid); end
`endif
    endtask

    task automatic test_hold();
        do_reset();
        push(4'd5);
        push(4'd6);
        rd_addr = 3'd1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (count !== 4'd2) begin bad++; $display("FAIL hold_count cycle=%0d got=%0d exp=2", c, count); end
        end
        total++; if (rd_data !== 4'd5 || data_out1 !== 4'd0) begin bad++; $display("FAIL hold_taps got rd1=%h out1=%h exp 5 0", rd_data, data_out1); end
        rd_addr = 3'd0; #1;
        total++; if (rd_data !== 4'd6) begin bad++; $display("FAIL hold_rd0 got=%h exp=6", rd_data); end
    endtask

    task automatic test_clear();
        do_reset();
        push(4'd1); push(4'd2); push(4'd3);
        clear = 1'b1; write = 1'b1; data_in = 4'hA;
        tick();
        clear = 1'b0; write = 1'b0;
        rd_addr = 3'd0; #1;
        total++; if (count !== 4'd1 || empty !== 1'b0) begin bad++; $display("FAIL clrw_count got cnt=%0d empty=%b exp 1/0", count, empty); end
        total++; if (rd_data !== 4'hA) begin bad++; $display("FAIL clrw_rd0 got=%h exp=a", rd_data); end
        rd_addr = 3'd1; #1;
        total++; if (rd_data !== 4'h0) begin bad++; $display("FAIL clrw_rd1 got=%h exp=0", rd_data); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rd_addr = 3'd0; #1;
        total++; if (count !== 4'd0 || empty !== 1'b1 || rd_data !== 4'h0) begin bad++; $display("FAIL clr_only got cnt=%0d empty=%b rd=%h exp 0/1/0", count, empty, rd_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int v = 1; v <= 8; v++) push(4'(v));
        reset = 1'b1; write = 1'b1; data_in = 4'hF;
        tick();
        reset = 1'b0; write = 1'b0;
        rd_addr = 3'd0; #1;
        total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rstmid_count got cnt=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
        total++; if (rd_data !== 4'h0 || data_out1 !== 4'h0 || data_out2 !== 4'h0) begin bad++; $display("FAIL rstmid_taps got %h %h %h exp 0 0 0", rd_data, data_out1, data_out2); end
`ifdef RAM_SHIFT_EVICT_EN
        total++; if (evict_valid !== 1'b0) begin bad++; $display("FAIL rstmid_evict got=%b exp=0", evict_valid); end
`endif
    endtask

    task automatic test_depth5();
        do_reset();
        for (int v = 1; v <= 7; v++) begin
            write5 = 1'b1; data_in5 = 4'(v);
            tick();
        end
        write5 = 1'b0;
        rd_addr5 = 3'd6; #1;
        total++; if (rd_data5 !== 4'h0) begin bad++; $display("FAIL d5_rd6 got=%h exp=0", rd_data5); end
        total++; if (count5 !== 4'd5 || full5 !== 1'b1) begin bad++; $display("FAIL d5_count got cnt=%0d full=%b exp 5/1", count5, full5); end
        total++; if (data_out15 !== 4'd3 || data_out25 !== 4'd4) begin bad++; $display("FAIL d5_oldest got %h %h exp 3 4", data_out15, data_out25); end
        rd_addr5 = 3'd4; #1;
        total++; if (rd_data5 !== 4'd3) begin bad++; $display("FAIL d5_rd4 got=%h exp=3", rd_data5); end
        rd_addr5 = 3'd0; #1;
        total++; if (rd_data5 !== 4'd7) begin bad++; $display("FAIL d5_rd0 got=%h exp=7", rd_data5); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_hold();
        test_clear();
        test_reset_mid();
        test_depth5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
